// File: rtl/morse_timing_decoder.sv
// morse_timing_decoder: tick-sampled Morse key decoder emitting 6-bit character codes.
// Optional word-space code (31) enabled by `define MORSE_WORD_GAP_EN.
module morse_timing_decoder #(
  parameter int CNT_W      = 8,
  parameter int DASH_MIN   = 3,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7,
  parameter int MAX_SYM    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key,
  output logic [5:0] letter,
  output logic       letter_valid,
  output logic [2:0] sym_count
);
`ifdef MORSE_WORD_GAP_EN
  localparam bit WG_EN = 1'b1;
`else
  localparam bit WG_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [MAX_SYM-1:0] r_sym;
  logic [3:0]         r_len;
  logic               r_err;
  logic               r_wact;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_dash;
  logic               w_full;
  logic               w_gap_done;
  logic               w_word_done;
  logic [5:0]         w_pat;
  logic [5:0]         w_code;
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_dash      = r_cnt >= CNT_W'(DASH_MIN);
  assign w_full      = r_len == 4'(MAX_SYM);
  assign w_gap_done  = w_cnt_inc >= CNT_W'(LETTER_GAP);
  assign w_word_done = WG_EN && r_wact && (w_cnt_inc >= CNT_W'(WORD_GAP));
  assign sym_count   = r_len[2:0];
  // Rebuild arrival order MSB-first behind a leading 1 so each length has its own code space.
  always_comb begin
    w_pat = 6'd1;
    for (int i = 0; i < 5; i++)
      if (4'(i) < r_len) w_pat = {w_pat[4:0], r_sym[i]};
    case (w_pat)
      6'b000101: w_code = 6'd1;
      6'b011000: w_code = 6'd2;
      6'b011010: w_code = 6'd3;
      6'b001100: w_code = 6'd4;
      6'b000010: w_code = 6'd5;
      6'b010010: w_code = 6'd6;
      6'b001110: w_code = 6'd7;
      6'b010000: w_code = 6'd8;
      6'b000100: w_code = 6'd9;
      6'b010111: w_code = 6'd10;
      6'b001101: w_code = 6'd11;
      6'b010100: w_code = 6'd12;
      6'b000111: w_code = 6'd13;
      6'b000110: w_code = 6'd14;
      6'b001111: w_code = 6'd15;
      6'b010110: w_code = 6'd16;
      6'b011101: w_code = 6'd17;
      6'b001010: w_code = 6'd18;
      6'b001000: w_code = 6'd19;
      6'b000011: w_code = 6'd20;
      6'b001001: w_code = 6'd21;
      6'b010001: w_code = 6'd22;
      6'b001011: w_code = 6'd23;
      6'b011001: w_code = 6'd24;
      6'b011011: w_code = 6'd25;
      6'b011100: w_code = 6'd26;
      6'b111111: w_code = 6'd32;
      6'b101111: w_code = 6'd33;
      6'b100111: w_code = 6'd34;
      6'b100011: w_code = 6'd35;
      6'b100001: w_code = 6'd36;
      6'b100000: w_code = 6'd37;
      6'b110000: w_code = 6'd38;
      6'b111000: w_code = 6'd39;
      6'b111100: w_code = 6'd40;
      6'b111110: w_code = 6'd41;
      default:   w_code = 6'd63;
    endcase
    if (r_err || r_len > 4'd5) w_code = 6'd63;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sym        <= '0;
      r_len        <= '0;
      r_err        <= 1'b0;
      r_wact       <= 1'b0;
      letter       <= '0;
      letter_valid <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      if (tick) begin
        case (r_state)
          IDLE: begin
            if (key) begin
              r_state <= MARK;
              r_cnt   <= CNT_W'(1);
              r_wact  <= 1'b0;
            end else if (w_word_done) begin
              letter       <= 6'd31;
              letter_valid <= 1'b1;
              r_wact       <= 1'b0;
            end else if (r_wact) begin
              r_cnt <= w_cnt_inc;
            end
          end
          MARK: begin
            if (key) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_state <= SPACE;
              r_cnt   <= CNT_W'(1);
              if (w_full) begin
                r_err <= 1'b1;
              end else begin
                r_sym <= r_sym | (MAX_SYM'(w_dash) << r_len);
                r_len <= r_len + 1'b1;
              end
            end
          end
          SPACE: begin
            if (key) begin
              r_state <= MARK;
              r_cnt   <= CNT_W'(1);
            end else if (w_gap_done) begin
              r_state      <= IDLE;
              r_cnt        <= w_cnt_inc;
              letter       <= w_code;
              letter_valid <= 1'b1;
              r_sym        <= '0;
              r_len        <= '0;
              r_err        <= 1'b0;
              r_wact       <= WG_EN;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_morse_timing_decoder.sv
// tb_morse_timing_decoder: randomized scenarios checked against a string-table Morse model.
// Word-space expectations follow `define MORSE_WORD_GAP_EN.
module tb_morse_timing_decoder;
  localparam int CNT_W = 8, DASH_MIN = 3, LETTER_GAP = 3, WORD_GAP = 7, MAX_SYM = 5;
`ifdef MORSE_WORD_GAP_EN
  localparam int WG = 1;
`else
  localparam int WG = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, key = 1'b0;
  logic [5:0] letter;
  logic letter_valid;
  logic [2:0] sym_count;
  int n_chk = 0, n_fail = 0, tk = 0, np = 0, ptk = 0, exp_ptk = 0, stray = 0, gap_cycles = 0;
  logic [5:0] got;
  int sc_q[$];
  string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                     "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                     "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
                     "...--", "....-", ".....", "-....", "--...", "---..", "----."};
  morse_timing_decoder #(.CNT_W(CNT_W), .DASH_MIN(DASH_MIN), .LETTER_GAP(LETTER_GAP),
    .WORD_GAP(WORD_GAP), .MAX_SYM(MAX_SYM)) dut (
    .clk(clk), .reset(reset), .tick(tick), .key(key),
    .letter(letter), .letter_valid(letter_valid), .sym_count(sym_count));
  always #5 clk = ~clk;
  function automatic logic [5:0] morse_code(input string p);
    if (p.len() > 5) return 6'd63;
    for (int i = 0; i < 36; i++)
      if (tbl[i] == p) return (i < 26) ? 6'(i + 1) : 6'(i + 6);
    return 6'd63;
  endfunction
  task automatic do_tick(input logic k);
    @(negedge clk);
    tick = 1'b1;
    key = k;
    @(posedge clk);
    #1;
    tk++;
    if (letter_valid) begin
      np++;
      got = letter;
      ptk = tk;
    end
    repeat (gap_cycles) begin
      @(negedge clk);
      tick = 1'b0;
      @(posedge clk);
      #1;
      if (letter_valid) stray++;
    end
  endtask
  task automatic send_char(input string pat, input bit rnd);
    int ml, gl;
    np = 0;
    sc_q = {};
    for (int s = 0; s < pat.len(); s++) begin
      if (pat[s] == "-") ml = rnd ? int'($urandom_range(DASH_MIN + 4, DASH_MIN)) : DASH_MIN;
      else ml = rnd ? int'($urandom_range(DASH_MIN - 1, 1)) : 1;
      gl = (s == pat.len() - 1) ? LETTER_GAP : (rnd ? int'($urandom_range(LETTER_GAP - 1, 1)) : 1);
      repeat (ml) do_tick(1'b1);
      if (s == pat.len() - 1) exp_ptk = tk + LETTER_GAP;
      for (int g = 1; g <= gl; g++) begin
        do_tick(1'b0);
        if (g == 1) sc_q.push_back(int'(sym_count));
      end
    end
    sc_q.push_back(int'(sym_count));
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk += 3;
    if (letter !== 6'd0) begin n_fail++; $display("FAIL reset_letter got %0d exp 0", letter); end
    if (letter_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", letter_valid); end
    if (sym_count !== 3'd0) begin n_fail++; $display("FAIL reset_symcount got %0d exp 0", sym_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_directed;
    string pats[5] = '{".", ".--.", ".....", "....-", "-----"};
    logic [5:0] exps[5] = '{6'd5, 6'd16, 6'd37, 6'd36, 6'd32};
    for (int c = 0; c < 5; c++) begin
      send_char(pats[c], 1'b0);
      n_chk += 3;
      if (np !== 1) begin n_fail++; $display("FAIL dir%0d_pulses got %0d exp 1", c, np); end
      if (got !== exps[c]) begin n_fail++; $display("FAIL dir%0d_letter got %0d exp %0d", c, got, exps[c]); end
      if (ptk !== exp_ptk) begin n_fail++; $display("FAIL dir%0d_latency got tick %0d exp %0d", c, ptk, exp_ptk); end
      for (int i = 0; i < sc_q.size(); i++) begin
        n_chk++;
        if (sc_q[i] != ((i == sc_q.size() - 1) ? 0 : i + 1)) begin
          n_fail++;
          $display("FAIL dir%0d_symcount[%0d] got %0d exp %0d", c, i, sc_q[i], (i == sc_q.size() - 1) ? 0 : i + 1);
        end
      end
      if (c == 0) begin
        np = 0;
        do_tick(1'b0);
        n_chk++;
        if (np !== 0) begin n_fail++; $display("FAIL valid_width got %0d extra pulses exp 0", np); end
      end
    end
  endtask
  task automatic test_overflow;
    send_char("......", 1'b0);
    n_chk += 2;
    if (np !== 1) begin n_fail++; $display("FAIL ovf_pulses got %0d exp 1", np); end
    if (got !== 6'd63) begin n_fail++; $display("FAIL ovf_letter got %0d exp 63", got); end
    send_char("-", 1'b0);
    n_chk++;
    if (got !== 6'd20 || np !== 1) begin n_fail++; $display("FAIL ovf_next got %0d (%0d pulses) exp 20", got, np); end
    np = 0;
    repeat (300) do_tick(1'b1);
    repeat (LETTER_GAP) do_tick(1'b0);
    n_chk++;
    if (got !== 6'd20 || np !== 1) begin n_fail++; $display("FAIL saturate got %0d (%0d pulses) exp 20", got, np); end
  endtask
  task automatic test_reset_mid;
    np = 0;
    do_tick(1'b1);
    do_tick(1'b0);
    do_tick(1'b1);
    do_tick(1'b0);
    do_tick(1'b1);
    @(negedge clk);
    tick = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_chk += 2;
    if (sym_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_symcount got %0d exp 0", sym_count); end
    if (letter !== 6'd0) begin n_fail++; $display("FAIL rstmid_letter got %0d exp 0", letter); end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) do_tick(1'b0);
    n_chk += 2;
    if (np !== 0) begin n_fail++; $display("FAIL rstmid_pulses got %0d exp 0", np); end
    if (letter !== 6'd0) begin n_fail++; $display("FAIL rstmid_hold got %0d exp 0", letter); end
    send_char(".", 1'b0);
    n_chk++;
    if (got !== 6'd5 || np !== 1) begin n_fail++; $display("FAIL rstmid_next got %0d (%0d pulses) exp 5", got, np); end
  endtask
  task automatic test_random;
    string p;
    logic [5:0] e;
    for (int c = 0; c < 40; c++) begin
      p = "";
      repeat ($urandom_range(6, 1)) begin
        if ($urandom_range(1, 0) == 1) p = {p, "-"};
        else p = {p, "."};
      end
      e = morse_code(p);
      send_char(p, 1'b1);
      n_chk += 3;
      if (np !== 1) begin n_fail++; $display("FAIL rnd%0d_pulses %s got %0d exp 1", c, p, np); end
      if (got !== e) begin n_fail++; $display("FAIL rnd%0d_letter %s got %0d exp %0d", c, p, got, e); end
      if (ptk !== exp_ptk) begin n_fail++; $display("FAIL rnd%0d_latency got tick %0d exp %0d", c, ptk, exp_ptk); end
      for (int i = 0; i < sc_q.size(); i++) begin
        n_chk++;
        if (sc_q[i] != ((i == sc_q.size() - 1) ? 0 : ((i + 1 > MAX_SYM) ? MAX_SYM : i + 1))) begin
          n_fail++;
          $display("FAIL rnd%0d_symcount[%0d] %s got %0d", c, i, p, sc_q[i]);
        end
      end
    end
  endtask
  task automatic test_word_gap;
    int t0;
    gap_cycles = 1;
    stray = 0;
    send_char(".", 1'b0);
    n_chk++;
    if (got !== 6'd5 || np !== 1) begin n_fail++; $display("FAIL wg_letter got %0d (%0d pulses) exp 5", got, np); end
    np = 0;
    t0 = tk;
    repeat (WORD_GAP - LETTER_GAP) do_tick(1'b0);
    n_chk++;
    if (np !== WG) begin n_fail++; $display("FAIL wg_pulses got %0d exp %0d", np, WG); end
    if (WG == 1) begin
      n_chk += 2;
      if (got !== 6'd31) begin n_fail++; $display("FAIL wg_code got %0d exp 31", got); end
      if (ptk !== t0 + WORD_GAP - LETTER_GAP) begin n_fail++; $display("FAIL wg_latency got tick %0d exp %0d", ptk, t0 + WORD_GAP - LETTER_GAP); end
    end
    np = 0;
    repeat (20) do_tick(1'b0);
    n_chk += 2;
    if (np !== 0) begin n_fail++; $display("FAIL wg_repeat got %0d pulses exp 0", np); end
    if (stray !== 0) begin n_fail++; $display("FAIL wg_width got %0d pulses in idle cycles exp 0", stray); end
    send_char("-", 1'b0);
    n_chk++;
    if (got !== 6'd20 || np !== 1) begin n_fail++; $display("FAIL wg_after got %0d (%0d pulses) exp 20", got, np); end
    gap_cycles = 0;
  endtask
  initial begin
    test_reset;
    test_directed;
    test_overflow;
    test_reset_mid;
    test_random;
    test_word_gap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
